// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply/divide engine for the MIPS execute stage. Results are
//   written to the HI/LO register write port.
//
//   op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//
//   Multiply is radix-2 shift-add over a 2*WIDTH accumulator (one bit per
//   cycle), or a single-cycle full-width product when FAST_MUL=1. Divide is
//   restoring division, one quotient bit per cycle. Both operate on operand
//   magnitudes; the sign fix-up happens in a dedicated FIX cycle.
//
// Ports
//   clk     in   clock, rising edge
//   resetn  in   asynchronous active-low reset
//   start   in   request an operation (accepted in IDLE/DONE when cancel=0)
//   op      in   [1:0] operation select
//   a       in   [WIDTH-1:0] rs operand (multiplicand / dividend)
//   b       in   [WIDTH-1:0] rt operand (multiplier / divisor)
//   cancel  in   exception flush, aborts an operation in flight
//   busy    out  registered, high in CALC and FIX
//   stall   out  combinational, busy or a start being accepted this cycle
//   done    out  registered, one-cycle pulse in DONE
//   hi      out  [WIDTH-1:0] remainder / high product
//   lo      out  [WIDTH-1:0] quotient / low product
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q;
  logic               div_q;     // 1 = divide, 0 = multiply
  logic               sa_q;
  logic               sb_q;
  logic [WIDTH-1:0]   opnd_q;    // multiplicand |a| or divisor |b|
  logic [2*WIDTH-1:0] acc_q;     // product accumulator; low half is the quotient in divide
  logic [WIDTH:0]     rem_q;     // partial remainder
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  // ---------------------------------------------------------------------------
  // Acceptance and operand conditioning
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             sa_d;
  logic             sb_d;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign accept = start & ~cancel & ((state_q == IDLE) | (state_q == DONE));
  assign stall  = busy_q | accept;

  // op[0]=1 selects the unsigned variants, whose operands are taken raw.
  // Magnitudes are WIDTH-bit unsigned, so |most-negative| keeps its bit pattern.
  assign sa_d  = ~op[0] & a[WIDTH-1];
  assign sb_d  = ~op[0] & b[WIDTH-1];
  assign abs_a = sa_d ? -a : a;
  assign abs_b = sb_d ? -b : b;

  // ---------------------------------------------------------------------------
  // Datapath step functions
  // ---------------------------------------------------------------------------
  // Shift-add: add the multiplicand into the top half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};

  // Restoring step: bring the next dividend bit into the remainder and try
  // subtracting the divisor. The extra MSB of the difference is the borrow.
  logic [WIDTH+1:0] div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {2'b00, opnd_q};
  assign div_ge    = ~div_diff[WIDTH+1];

  logic [2*WIDTH-1:0] fast_prod;
  generate
    if (FAST_MUL) begin : g_fast
      assign fast_prod = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
    end else begin : g_iter
      assign fast_prod = '0;
    end
  endgenerate

  // Sign fix-up applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
  assign quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            div_q   <= op[1];
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            // Multiply: b is shifted out of the accumulator, a is added in.
            // Divide: a is shifted out of the accumulator, b is subtracted.
            opnd_q  <= op[1] ? abs_b : abs_a;
            acc_q   <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end else begin
            state_q <= IDLE;
          end
        end

        CALC: begin
          if (cancel) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!div_q && FAST_MUL) begin
            acc_q   <= fast_prod;
            state_q <= FIX;
          end else begin
            if (div_q) begin
              rem_q             <= div_ge ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
              acc_q[WIDTH-1:0]  <= {acc_q[WIDTH-2:0], div_ge};
            end else begin
              acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              state_q <= FIX;
            end
          end
        end

        FIX: begin
          busy_q <= 1'b0;
          if (cancel) begin
            state_q <= IDLE;
          end else begin
            hi_q    <= div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo_q    <= div_q ? quo_fix : prod_fix[WIDTH-1:0];
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Drives one shared stimulus stream into two instances (iterative and
//   FAST_MUL) and checks both with a scoreboard: expected {hi,lo} and the
//   cycle in which done must appear are queued at acceptance, and a monitor
//   pops and compares whenever an instance pulses done.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic         cancel;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy_s, stall_s, done_s;
  logic         busy_f, stall_f, done_f;
  logic [W-1:0] hi_s, lo_s, hi_f, lo_f;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b0)) dut_s (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy_s), .stall(stall_s), .done(done_s),
    .hi(hi_s), .lo(lo_s)
  );

  muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b1)) dut_f (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy_f), .stall(stall_f), .done(done_f),
    .hi(hi_f), .lo(lo_f)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
  } exp_t;

  exp_t q_s[$];
  exp_t q_f[$];
  logic [63:0] held = '0;   // last committed {hi,lo}
  int          cur_c0 = 0;

  // Reference: plain arithmetic on the architectural rules.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sp;
    logic        sx, sy;
    logic [31:0] mx, my, qq, rr;
    if (o == 2'b00) begin
      sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      return sp;
    end
    if (o == 2'b01) return {32'd0, x} * {32'd0, y};
    sx = ~o[0] & x[31];
    sy = ~o[0] & y[31];
    mx = sx ? -x : x;
    my = sy ? -y : y;
    if (my == 32'd0) begin
      qq = '1;
      rr = mx;
    end else begin
      qq = mx / my;
      rr = mx % my;
    end
    if (sx ^ sy) qq = -qq;
    if (sx) rr = -rr;
    return {rr, qq};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1) begin
      if (done_s) begin
        vectors++;
        if (q_s.size() == 0) begin
          miscompares++;
          $display("FAIL slow_unexpected_done: got hi=%h lo=%h, expected no done (cycle %0d)", hi_s, lo_s, cyc);
        end else begin
          e = q_s.pop_front();
          if (hi_s !== e.hi || lo_s !== e.lo || cyc != e.due) begin
            miscompares++;
            $display("FAIL slow_result: got hi=%h lo=%h cycle=%0d, expected hi=%h lo=%h cycle=%0d",
                     hi_s, lo_s, cyc, e.hi, e.lo, e.due);
          end else
            $display("txn slow hi=%h lo=%h cycle=%0d ok", hi_s, lo_s, cyc);
        end
      end
      if (done_f) begin
        vectors++;
        if (q_f.size() == 0) begin
          miscompares++;
          $display("FAIL fast_unexpected_done: got hi=%h lo=%h, expected no done (cycle %0d)", hi_f, lo_f, cyc);
        end else begin
          e = q_f.pop_front();
          if (hi_f !== e.hi || lo_f !== e.lo || cyc != e.due) begin
            miscompares++;
            $display("FAIL fast_result: got hi=%h lo=%h cycle=%0d, expected hi=%h lo=%h cycle=%0d",
                     hi_f, lo_f, cyc, e.hi, e.lo, e.due);
          end else
            $display("txn fast hi=%h lo=%h cycle=%0d ok", hi_f, lo_f, cyc);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (entered and left at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit track);
    logic [63:0] e;
    int n = 0;
    while (busy_s && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("issue_wait", 64'(busy_s), 64'd0);
    start = 1'b1; op = o; a = x; b = y;
    #1;
    check("accept_stall_busy", 64'({stall_s, busy_s, stall_f, busy_f}), 64'b1010);
    cur_c0 = cyc;
    if (track) begin
      e = model(o, x, y);
      q_s.push_back('{hi: e[63:32], lo: e[31:0], due: cyc + 34});
      q_f.push_back('{hi: e[63:32], lo: e[31:0], due: (o[1] ? cyc + 34 : cyc + 3)});
      held = e;
    end
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic wait_done();
    int  k   = 1;
    bit  bad = 1'b0;
    while (!done_s && k < 100) begin
      if (!busy_s) bad = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    check("busy_window", 64'({bad, done_s, busy_s}), 64'b010);
    check("done_latency", 64'(k), 64'd34);
    check("stall_in_done", 64'(stall_s), 64'd0);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    issue(o, x, y, 1'b1);
    wait_done();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    resetn = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 64'({busy_s, done_s, busy_f, done_f}), 64'd0);
    check("reset_hilo_s", {hi_s, lo_s}, 64'd0);
    check("reset_hilo_f", {hi_f, lo_f}, 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(2'b00, 32'hFFFF_FFFD, 32'd5);
    run(2'b10, 32'hFFFF_FFF9, 32'd2);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b11, 32'd7, 32'd0);
    run(2'b10, 32'hFFFF_FFF9, 32'd0);
    run(2'b00, 32'h8000_0000, 32'h8000_0000);
    run(2'b11, 32'd100, 32'd7);
    run(2'b01, 32'd3, 32'd4);           // accepted in the DONE cycle above

    // Cancel mid-operation: results held, no done
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    while (cyc < cur_c0 + 10) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    check("cancel_to_idle", 64'({busy_s, done_s, busy_f, done_f}), 64'd0);
    cancel = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("cancel_hold_s", {hi_s, lo_s}, held);
    check("cancel_hold_f", {hi_f, lo_f}, held);

    // Cancel in DONE blocks a start but keeps the committed result
    run(2'b10, pick(), pick());
    start = 1'b1; cancel = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
    #1;
    check("stall_cancel_in_done", 64'({stall_s, stall_f}), 64'd0);
    @(posedge clk); #1;
    check("cancel_blocks_accept", 64'({busy_s, done_s, busy_f}), 64'd0);
    check("cancel_done_keeps", {hi_s, lo_s}, held);
    start = 1'b0; cancel = 1'b0;
    @(posedge clk); #1;

    // Reset mid-operation
    issue(2'b10, pick(), pick(), 1'b0);
    while (cyc < cur_c0 + 5) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #1;
    check("midop_reset_flags", 64'({busy_s, done_s, busy_f, done_f}), 64'd0);
    check("midop_reset_hilo", {hi_s, lo_s, hi_f, lo_f} == 128'd0 ? 64'd0 : 64'd1, 64'd0);
    held = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run(2'b00, 32'hFFFF_FFFD, 32'd5);

    // Randomized operations with random gaps (zero gap = back-to-back)
    for (int i = 0; i < 40; i++) begin
      int gap;
      run(2'($urandom), pick(), pick());
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(q_s.size() + q_f.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
